// File: rtl/sector_resampler_pp_pkg.sv
// Shared types and helpers for sector_resampler_pp: FSM states, points-per-mode
// and angle range lookups, minimum strobe spacing.
package sr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ANGLE,
    ST_READ,
    ST_EMIT,
    ST_ADVANCE,
    ST_GAP
  } sr_state_t;

  // Mode 3 is reserved and folds onto mode 0.
  function automatic logic [8:0] mode_points(input logic [1:0] mode,
                                             input int unsigned p0,
                                             input int unsigned p1,
                                             input int unsigned p2);
    case (mode)
      2'd1:    return 9'(p1);
      2'd2:    return 9'(p2);
      default: return 9'(p0);
    endcase
  endfunction

  function automatic logic [15:0] angle_max(input logic [8:0] pts,
                                            input int unsigned sectors);
    return 16'(sectors * pts);
  endfunction

  // Worst-case ADVANCE length plus EMIT/READ/GAP overhead.
  function automatic int unsigned pt_gap_min(input int unsigned depth,
                                             input int unsigned pts0);
    return depth / pts0 + 4;
  endfunction

endpackage

// File: rtl/sector_resampler_pp_if.sv
// Sample-in / point-out signal bundle of sector_resampler_pp.
interface sector_resampler_pp_if #(
  parameter int unsigned DW = 64
);
  logic          i_sector_sync;
  logic [7:0]    i_sector_idx;
  logic [15:0]   i_angle_zero;
  logic [1:0]    i_reso_mode;
  logic          i_smp_vld;
  logic [DW-1:0] i_smp_data;
  logic          o_pt_vld;
  logic [15:0]   o_pt_angle;
  logic [DW-1:0] o_pt_data;
  logic          o_pt_empty;
  logic          o_busy;
  logic          o_overrun;

  modport master (
    output i_sector_sync, i_sector_idx, i_angle_zero, i_reso_mode, i_smp_vld, i_smp_data,
    input  o_pt_vld, o_pt_angle, o_pt_data, o_pt_empty, o_busy, o_overrun
  );

  modport slave (
    input  i_sector_sync, i_sector_idx, i_angle_zero, i_reso_mode, i_smp_vld, i_smp_data,
    output o_pt_vld, o_pt_angle, o_pt_data, o_pt_empty, o_busy, o_overrun
  );
endinterface

// File: rtl/sector_resampler_pp_bank_ram.sv
// One ping-pong bank: simple dual-port RAM with registered 1-cycle read.
module sector_bank_ram #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sector_resampler_pp.sv
// Ping-pong per-sector capture, re-emitted as N evenly spaced angle-tagged points.
// Define SR_STATS_EN to add o_last_m and o_drop_cnt.
module sector_resampler_pp
  import sr_pkg::*;
#(
  parameter int unsigned DW        = 64,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned PTS0      = 90,
  parameter int unsigned PTS1      = 180,
  parameter int unsigned PTS2      = 360,
  parameter int unsigned SECTORS   = 40,
  parameter int unsigned PT_GAP    = 252,
  parameter int unsigned START_DLY = 8
) (
  input  logic i_clk_50m,
  input  logic i_rst,
  sector_resampler_pp_if.slave sr
`ifdef SR_STATS_EN
  ,
  output logic [8:0]  o_last_m,
  output logic [15:0] o_drop_cnt
`endif
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned WCW     = $clog2(DEPTH + 1);
  localparam int unsigned ACW     = $clog2(DEPTH + PTS2) + 1;
  localparam int unsigned GAP_MIN = pt_gap_min(DEPTH, PTS0);
  localparam int unsigned GAP_EFF = (PT_GAP < GAP_MIN) ? GAP_MIN : PT_GAP;
  localparam int unsigned CYW     = $clog2(GAP_EFF + 1);
  localparam int unsigned DLW     = $clog2(START_DLY + 1);

  logic [WCW-1:0] wr_cnt, m_lat;
  logic           wsel;
  logic [1:0]     mode_lat;
  logic [7:0]     idx_lat;
  logic [15:0]    zero_lat;
  sr_state_t      state, state_nxt;
  logic [DLW-1:0] dly_cnt;
  logic [CYW-1:0] cyc;
  logic [8:0]     k, src, n_pts;
  logic [ACW-1:0] acc;
  logic [15:0]    angle, amax, base;
  logic [17:0]    base_raw;
  logic           gap_done, wr_en, wr_bank, we0, we1;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  q0, q1, ram_q;

  // A sample coincident with sync opens the new sector at index 0 of the other bank.
  always_comb begin
    wr_bank = sr.i_sector_sync ? ~wsel : wsel;
    wr_addr = sr.i_sector_sync ? '0 : wr_cnt[AW-1:0];
    wr_en   = sr.i_smp_vld && (sr.i_sector_sync || wr_cnt < WCW'(DEPTH));
    we0     = wr_en && !wr_bank;
    we1     = wr_en && wr_bank;
    ram_q   = wsel ? q0 : q1;
  end

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      wsel     <= 1'b0;
      wr_cnt   <= '0;
      m_lat    <= '0;
      mode_lat <= '0;
      idx_lat  <= '0;
      zero_lat <= '0;
    end else if (sr.i_sector_sync) begin
      m_lat    <= wr_cnt;
      wsel     <= ~wsel;
      wr_cnt   <= sr.i_smp_vld ? WCW'(1) : '0;
      mode_lat <= sr.i_reso_mode;
      idx_lat  <= sr.i_sector_idx;
      zero_lat <= sr.i_angle_zero;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  sector_bank_ram #(.DW(DW), .DEPTH(DEPTH)) u_bank0 (
    .clk(i_clk_50m), .we(we0), .waddr(wr_addr), .wdata(sr.i_smp_data),
    .raddr(src[AW-1:0]), .rdata(q0)
  );

  sector_bank_ram #(.DW(DW), .DEPTH(DEPTH)) u_bank1 (
    .clk(i_clk_50m), .we(we1), .waddr(wr_addr), .wdata(sr.i_smp_data),
    .raddr(src[AW-1:0]), .rdata(q1)
  );

  always_comb begin
    n_pts    = mode_points(mode_lat, PTS0, PTS1, PTS2);
    amax     = angle_max(n_pts, SECTORS);
    base_raw = 18'(idx_lat) * 18'(n_pts) + 18'(zero_lat);
    base     = (base_raw >= 18'(amax)) ? 16'(base_raw - 18'(amax)) : base_raw[15:0];
    gap_done = cyc >= CYW'(GAP_EFF - 2);
  end

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    sr.o_pt_vld    = 1'b0;
    sr.o_pt_empty  = 1'b0;
    sr.o_pt_angle  = '0;
    sr.o_pt_data   = '0;
    sr.o_busy      = (state != ST_IDLE);
    sr.o_overrun   = sr.i_sector_sync && (state != ST_IDLE);
    if (sr.i_sector_sync) begin
      state_nxt = ST_ANGLE;
    end else begin
      case (state)
        ST_ANGLE:   if (dly_cnt == DLW'(START_DLY - 1)) state_nxt = ST_READ;
        ST_READ:    state_nxt = ST_EMIT;
        ST_EMIT:    state_nxt = ST_ADVANCE;
        ST_ADVANCE: if (acc < ACW'(n_pts)) state_nxt = ST_GAP;
        ST_GAP:     if (gap_done) state_nxt = (k == n_pts) ? ST_IDLE : ST_READ;
        default:    state_nxt = ST_IDLE;
      endcase
    end
    if (state == ST_EMIT) begin
      sr.o_pt_vld   = 1'b1;
      sr.o_pt_angle = angle;
      sr.o_pt_empty = (m_lat == '0);
      sr.o_pt_data  = (m_lat == '0) ? '0 : ram_q;
    end
  end

  // src tracks floor(k*M/N): acc holds k*M mod N, one subtract per ADVANCE cycle.
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      dly_cnt <= '0;
      cyc     <= '0;
      k       <= '0;
      src     <= '0;
      acc     <= '0;
      angle   <= '0;
    end else if (sr.i_sector_sync) begin
      dly_cnt <= '0;
    end else begin
      case (state)
        ST_ANGLE: begin
          if (dly_cnt == DLW'(START_DLY - 1)) begin
            angle <= base;
            k     <= '0;
            src   <= '0;
            acc   <= '0;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        ST_EMIT: begin
          k   <= k + 1'b1;
          acc <= acc + ACW'(m_lat);
          cyc <= CYW'(1);
        end
        ST_ADVANCE: begin
          cyc <= cyc + 1'b1;
          if (acc >= ACW'(n_pts)) begin
            acc <= acc - ACW'(n_pts);
            src <= src + 1'b1;
          end
        end
        ST_GAP: begin
          cyc <= cyc + 1'b1;
          if (gap_done) angle <= (angle == amax - 16'd1) ? '0 : angle + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SR_STATS_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) drop_cnt <= '0;
    else if (sr.i_smp_vld && !sr.i_sector_sync && wr_cnt == WCW'(DEPTH) && drop_cnt != '1)
      drop_cnt <= drop_cnt + 1'b1;
  end

  always_comb begin
    o_last_m   = 9'(m_lat);
    o_drop_cnt = drop_cnt;
  end
`endif

endmodule

// File: tb/tb_sector_resampler_pp.sv
// Directed bench for sector_resampler_pp with a short strobe gap (PT_GAP=16).
module tb_sector_resampler_pp;
  localparam int GAP = 16;
  localparam int LAT = 10;  // sync edge to first strobe: START_DLY + READ + EMIT

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  sector_resampler_pp_if #(.DW(64)) bus ();

`ifdef SR_STATS_EN
  logic [8:0]  last_m;
  logic [15:0] drop_cnt;
`endif

  sector_resampler_pp #(.PT_GAP(GAP)) dut (
    .i_clk_50m(clk),
    .i_rst(rst),
    .sr(bus)
`ifdef SR_STATS_EN
    , .o_last_m(last_m), .o_drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.i_smp_vld  = 1'b1;
      bus.i_smp_data = 64'(base + i);
      align();
    end
    bus.i_smp_vld = 1'b0;
  endtask

  task automatic do_sync(input int idx, input int zero, input int mode);
    bus.i_sector_sync = 1'b1;
    bus.i_sector_idx  = 8'(idx);
    bus.i_angle_zero  = 16'(zero);
    bus.i_reso_mode   = 2'(mode);
    align();
    bus.i_sector_sync = 1'b0;
  endtask

  task automatic wait_pt(output logic [63:0] d, output logic [15:0] a, output logic e,
                         output int n, output bit ok);
    ok = 1'b0; n = 0; d = '0; a = '0; e = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (bus.o_pt_vld === 1'b1) begin
        d = bus.o_pt_data; a = bus.o_pt_angle; e = bus.o_pt_empty; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_pt(input string t, input int k, input int exp_d, input int exp_a,
                        input bit exp_e, input int exp_gap);
    logic [63:0] d;
    logic [15:0] a;
    logic        e;
    int          n;
    bit          ok;
    wait_pt(d, a, e, n, ok);
    chk($sformatf("%s_strobe[%0d]", t, k), 64'(ok), 64'(1));
    chk($sformatf("%s_data[%0d]", t, k), d, 64'(exp_d));
    chk($sformatf("%s_angle[%0d]", t, k), 64'(a), 64'(exp_a));
    chk($sformatf("%s_empty[%0d]", t, k), 64'(e), 64'(exp_e));
    chk($sformatf("%s_gap[%0d]", t, k), 64'(n), 64'(exp_gap));
  endtask

  task automatic wait_idle(input string t, input int bound, input bit check_extra);
    int extra = 0;
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.o_pt_vld === 1'b1) extra++;
      if (bus.o_busy === 1'b0) begin ok = 1'b1; break; end
    end
    chk($sformatf("%s_idle", t), 64'(ok), 64'(1));
    if (check_extra) chk($sformatf("%s_extra_pts", t), 64'(extra), 64'(0));
  endtask

  initial begin
    int a;
    rst = 1'b1;
    bus.i_sector_sync = 1'b0;
    bus.i_sector_idx  = '0;
    bus.i_angle_zero  = '0;
    bus.i_reso_mode   = '0;
    bus.i_smp_vld     = 1'b0;
    bus.i_smp_data    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", 64'(bus.o_pt_vld), 64'(0));
    chk("rst_busy", 64'(bus.o_busy), 64'(0));
    chk("rst_overrun", 64'(bus.o_overrun), 64'(0));
    chk("rst_angle", 64'(bus.o_pt_angle), 64'(0));
    chk("rst_data", bus.o_pt_data, 64'(0));
    chk("rst_empty", 64'(bus.o_pt_empty), 64'(0));
    align();

    // M = N = 90: identity, angles 3*90+100 = 370..459
    send(90, 0);
    do_sync(3, 100, 0);
    for (int k = 0; k < 90; k++) chk_pt("t1", k, k, 370 + k, 1'b0, (k == 0) ? LAT : GAP);
    wait_idle("t1", 200, 1'b1);
    align();

    // M = 120 > N = 90: decimation, data = floor(4k/3), last 118
    send(120, 0);
    do_sync(0, 0, 0);
    for (int k = 0; k < 90; k++) chk_pt("t2", k, (k * 120) / 90, k, 1'b0, (k == 0) ? LAT : GAP);
    wait_idle("t2", 200, 1'b1);
    align();

    // M = 60 < N = 180: each sample three times; base 39*180+100 = 7120, wraps 7199 -> 0
    send(60, 0);
    do_sync(39, 100, 1);
    for (int k = 0; k < 180; k++) begin
      a = 7120 + k;
      if (a >= 7200) a = a - 7200;
      chk_pt("t3", k, k / 3, a, 1'b0, (k == 0) ? LAT : GAP);
    end
    wait_idle("t3", 200, 1'b1);
    align();

    // empty sector, mode 3 folds to 90 points; 39*90+200 = 3710 reduced by 3600 -> 110
    do_sync(39, 200, 3);
    for (int k = 0; k < 90; k++) chk_pt("t4", k, 0, 110 + k, 1'b1, (k == 0) ? LAT : GAP);
    wait_idle("t4", 200, 1'b1);
    align();

    // abort after 30 points; next strobe belongs to the new (empty) sector at 7*90
    send(90, 1000);
    do_sync(5, 0, 0);
    for (int k = 0; k < 30; k++) chk_pt("t5", k, 1000 + k, 450 + k, 1'b0, (k == 0) ? LAT : GAP);
    align();
    bus.i_sector_sync = 1'b1;
    bus.i_sector_idx  = 8'd7;
    bus.i_angle_zero  = 16'd0;
    bus.i_reso_mode   = 2'd0;
    @(negedge clk);
    chk("t5_overrun", 64'(bus.o_overrun), 64'(1));
    chk("t5_busy", 64'(bus.o_busy), 64'(1));
    align();
    bus.i_sector_sync = 1'b0;
    for (int k = 0; k < 90; k++) chk_pt("t5b", k, 0, 630 + k, 1'b1, (k == 0) ? LAT : GAP);
    wait_idle("t5b", 200, 1'b1);
    align();

    // 300 samples saturate at DEPTH: M = 256, data = floor(256k/90), last 253
    send(300, 0);
    do_sync(0, 0, 0);
`ifdef SR_STATS_EN
    chk("t6_drop_cnt", 64'(drop_cnt), 64'(44));
    chk("t6_last_m", 64'(last_m), 64'(256));
`endif
    for (int k = 0; k < 90; k++) chk_pt("t6", k, (k * 256) / 90, k, 1'b0, (k == 0) ? LAT : GAP);
    wait_idle("t6", 200, 1'b1);
    align();

    // asynchronous reset while a point strobe is being presented
    send(10, 16'h700);
    do_sync(1, 0, 0);
    for (int k = 0; k < 5; k++) chk_pt("t7", k, 16'h700, 90 + k, 1'b0, (k == 0) ? LAT : GAP);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_vld", 64'(bus.o_pt_vld), 64'(0));
    chk("t7_rst_busy", 64'(bus.o_busy), 64'(0));
    chk("t7_rst_data", bus.o_pt_data, 64'(0));
    chk("t7_rst_angle", 64'(bus.o_pt_angle), 64'(0));
    align();
    align();
    rst = 1'b0;

    // after reset: mode 2 (360 points), 3 samples, base 5
    send(3, 16'h55);
    do_sync(0, 5, 2);
    chk_pt("t8", 0, 16'h55, 5, 1'b0, LAT);
    chk_pt("t8", 1, 16'h55, 6, 1'b0, GAP);
    chk_pt("t8", 2, 16'h55, 7, 1'b0, GAP);
    wait_idle("t8", 8000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
